// File: rtl/sbqm_queue_counter.sv
// Queue occupancy counter: synchronised, debounced entrance/exit photocells drive a saturating PCount.
// Define SBQM_ERR_FLAGS_EN to build the sticky OverflowErr/UnderflowErr logic; otherwise both are tied low.
module sbqm_queue_counter #(
    parameter int CNT_W           = 3,
    parameter int MAX_COUNT       = 7,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FrontSensor,
    input  logic             BackSensor,
    output logic [CNT_W-1:0] PCount,
    output logic             Full,
    output logic             Empty,
    output logic             EnterPulse,
    output logic             LeavePulse,
    output logic             OverflowErr,
    output logic             UnderflowErr
);

    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, QUAL, HELD, REL} dbState_t;

    // Bit 0 is the entrance sensor, bit 1 the exit sensor.
    logic [1:0] rawIn;
    logic [1:0] syncP0;
    logic [1:0] syncP1;
    logic [1:0] evtP2;
    logic [CNT_W-1:0] countNext;

    assign rawIn = {BackSensor, FrontSensor};

    function automatic logic [CNT_W-1:0] satStep(input logic [CNT_W-1:0] cur,
                                                 input logic enter, input logic leave);
        logic [CNT_W-1:0] res;
        res = cur;
        if (enter && !leave && (cur != CNT_MAX))
            res = cur + CNT_W'(1);
        else if (leave && !enter && (cur != '0))
            res = cur - CNT_W'(1);
        return res;
    endfunction

    // Stage p0/p1: two-flop synchroniser per sensor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncP0 <= '0;
            syncP1 <= '0;
        end else begin
            syncP0 <= rawIn;
            syncP1 <= syncP0;
        end
    end

    // Stage p2: debounce FSM per sensor, registered event pulse on accepted rising level
    for (genvar g = 0; g < 2; g++) begin : gDebounce
        dbState_t        state, stateNext;
        logic [DB_W-1:0] cnt, cntNext;
        logic            evtNext;
        logic            evtReg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= IDLE;
                cnt    <= '0;
                evtReg <= 1'b0;
            end else begin
                state  <= stateNext;
                cnt    <= cntNext;
                evtReg <= evtNext;
            end
        end

        always_comb begin
            stateNext = state;
            cntNext   = cnt;
            case (state)
                IDLE: if (syncP1[g]) begin
                    stateNext = QUAL;
                    cntNext   = DB_W'(1);
                end
                QUAL: if (!syncP1[g])
                    stateNext = IDLE;
                else if (cnt == DB_LAST)
                    stateNext = HELD;
                else
                    cntNext = cnt + DB_W'(1);
                HELD: if (!syncP1[g]) begin
                    stateNext = REL;
                    cntNext   = DB_W'(1);
                end
                REL: if (syncP1[g])
                    stateNext = HELD;
                else if (cnt == DB_LAST)
                    stateNext = IDLE;
                else
                    cntNext = cnt + DB_W'(1);
                default: stateNext = IDLE;
            endcase
        end

        always_comb begin
            evtNext = (state == QUAL) && syncP1[g] && (cnt == DB_LAST);
        end

        assign evtP2[g] = evtReg;
    end

    assign EnterPulse = evtP2[0];
    assign LeavePulse = evtP2[1];

    // Stage p3: saturating count; flags derive from the next value so they never lag PCount
    assign countNext = satStep(PCount, EnterPulse, LeavePulse);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCount <= '0;
            Full   <= 1'b0;
            Empty  <= 1'b1;
        end else begin
            PCount <= countNext;
            Full   <= (countNext == CNT_MAX);
            Empty  <= (countNext == '0);
        end
    end

`ifdef SBQM_ERR_FLAGS_EN
    logic ovfHit;
    logic udfHit;

    assign ovfHit = EnterPulse && !LeavePulse && (PCount == CNT_MAX);
    assign udfHit = LeavePulse && !EnterPulse && (PCount == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OverflowErr  <= 1'b0;
            UnderflowErr <= 1'b0;
        end else begin
            if (ovfHit) OverflowErr  <= 1'b1;
            if (udfHit) UnderflowErr <= 1'b1;
        end
    end
`else
    assign OverflowErr  = 1'b0;
    assign UnderflowErr = 1'b0;
`endif

endmodule

// File: tb/tb_sbqm_queue_counter.sv
// Directed self-checking bench for sbqm_queue_counter (default parameters).
module tb_sbqm_queue_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       FrontSensor;
    logic       BackSensor;
    logic [2:0] PCount;
    logic       Full;
    logic       Empty;
    logic       EnterPulse;
    logic       LeavePulse;
    logic       OverflowErr;
    logic       UnderflowErr;

    int checks = 0;
    int errors = 0;
    int enterSeen = 0;
    int leaveSeen = 0;
    int base;

`ifdef SBQM_ERR_FLAGS_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    sbqm_queue_counter #(.CNT_W(3), .MAX_COUNT(7), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .FrontSensor(FrontSensor), .BackSensor(BackSensor),
        .PCount(PCount), .Full(Full), .Empty(Empty), .EnterPulse(EnterPulse),
        .LeavePulse(LeavePulse), .OverflowErr(OverflowErr), .UnderflowErr(UnderflowErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (EnterPulse === 1'b1) enterSeen++;
        if (LeavePulse === 1'b1) leaveSeen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulseSensor(input logic f, input logic b);
        FrontSensor = f;
        BackSensor  = b;
        tick(7);
        FrontSensor = 1'b0;
        BackSensor  = 1'b0;
        tick(8);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        FrontSensor = 1'b0;
        BackSensor  = 1'b0;
        tick(2);
        check("rst_pcount", PCount, 0);
        check("rst_empty", Empty, 1);
        check("rst_full", Full, 0);
        check("rst_enter", EnterPulse, 0);
        check("rst_leave", LeavePulse, 0);
        check("rst_ovf", OverflowErr, 0);
        check("rst_udf", UnderflowErr, 0);
        rst = 1'b0;
        tick(2);

        // Clean entry held for 10 cycles: pulse after edge 6, count after edge 7
        base = enterSeen;
        FrontSensor = 1'b1;
        tick(5);
        check("t1_pulse_e5", EnterPulse, 0);
        tick(1);
        check("t1_pulse_e6", EnterPulse, 1);
        check("t1_pcount_e6", PCount, 0);
        check("t1_empty_e6", Empty, 1);
        tick(1);
        check("t1_pulse_e7", EnterPulse, 0);
        check("t1_pcount_e7", PCount, 1);
        check("t1_empty_e7", Empty, 0);
        tick(3);
        FrontSensor = 1'b0;
        tick(10);
        check("t1_one_event", enterSeen - base, 1);
        check("t1_pcount_end", PCount, 1);

        // Too-short pulse is rejected
        base = enterSeen;
        FrontSensor = 1'b1;
        tick(3);
        FrontSensor = 1'b0;
        tick(10);
        check("t2_no_event", enterSeen - base, 0);
        check("t2_pcount", PCount, 1);

        // Low glitch while HELD returns to HELD without a new event
        base = enterSeen;
        FrontSensor = 1'b1;
        tick(8);
        FrontSensor = 1'b0;
        tick(2);
        FrontSensor = 1'b1;
        tick(10);
        FrontSensor = 1'b0;
        tick(10);
        check("t3_one_event", enterSeen - base, 1);
        check("t3_pcount", PCount, 2);

        // Eight entries from empty saturate at 7
        doReset();
        check("t4_start", PCount, 0);
        for (int i = 1; i <= 8; i++) begin
            pulseSensor(1'b1, 1'b0);
            check($sformatf("t4_pcount_%0d", i), PCount, (i > 7) ? 7 : i);
            check($sformatf("t4_full_%0d", i), Full, (i >= 7) ? 1 : 0);
        end
        check("t4_ovf", OverflowErr, ERR_EN);
        check("t4_udf", UnderflowErr, 0);

        // Leave at empty
        doReset();
        check("t5_ovf_cleared", OverflowErr, 0);
        base = leaveSeen;
        pulseSensor(1'b0, 1'b1);
        check("t5_leave_event", leaveSeen - base, 1);
        check("t5_pcount", PCount, 0);
        check("t5_empty", Empty, 1);
        check("t5_udf", UnderflowErr, ERR_EN);

        // Simultaneous enter and leave at PCount=3
        doReset();
        for (int i = 0; i < 3; i++) pulseSensor(1'b1, 1'b0);
        check("t6_pcount3", PCount, 3);
        FrontSensor = 1'b1;
        BackSensor  = 1'b1;
        tick(6);
        check("t6_enter", EnterPulse, 1);
        check("t6_leave", LeavePulse, 1);
        tick(1);
        check("t6_pcount_hold", PCount, 3);
        FrontSensor = 1'b0;
        BackSensor  = 1'b0;
        tick(8);
        check("t6_pcount_after", PCount, 3);
        check("t6_ovf", OverflowErr, 0);

        // Asynchronous reset in the middle of qualification
        FrontSensor = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        check("t7_async_pcount", PCount, 0);
        check("t7_async_empty", Empty, 1);
        check("t7_async_full", Full, 0);
        FrontSensor = 1'b0;
        tick(2);
        rst = 1'b0;
        base = enterSeen;
        tick(12);
        check("t7_no_event", enterSeen - base, 0);
        check("t7_pcount", PCount, 0);
        check("t7_empty", Empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbqm_queue_counter.md
Name: sbqm_queue_counter

Overview:
- Producer side of the wait-time lookup path. Its PCount output drives the 3-bit PCount address of the wait-time ROM.
- Converts the raw entrance photocell (person joins the queue) and exit photocell (person leaves the queue toward a teller) into a saturating occupancy count.
- Each sensor input is synchronised and debounced, and a registered count is produced.
- Also provides full and empty flags for the display and the door logic.

Parameters:
- CNT_W, 3, width of PCount. Must match the ROM address width.
- MAX_COUNT, 7, occupancy at which full asserts and further entries are rejected. Must be ≤ 2^CNT_W−1.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a sensor level change. Must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- FrontSensor  in  1  raw entrance photocell, asynchronous, high = beam broken
- BackSensor  in  1  raw exit photocell, asynchronous, high = beam broken
- PCount  out  CNT_W  registered queue occupancy
- Full  out  1  registered, high when PCount == MAX_COUNT
- Empty  out  1  registered, high when PCount == 0
- EnterPulse  out  1  one-cycle pulse on an accepted entry event (pre-saturation)
- LeavePulse  out  1  one-cycle pulse on an accepted leave event (pre-saturation)
- OverflowErr  out  1  sticky error flag (see Optional Feature)
- UnderflowErr  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high): all flops clear.
  - PCount=0, Empty=1, Full=0, EnterPulse=0, LeavePulse=0, OverflowErr=0, UnderflowErr=0.
  - Both debounce FSMs go to IDLE and their counters clear.
  - Reset asserted mid-debounce or mid-count discards all progress. No event is emitted on reset release.
- Synchronisation: each sensor passes through a 2-flop synchroniser. Only the second-stage output (s) is used downstream.
- Debounce FSM, one instance per sensor, with qualification counter cnt (width clog2(DEBOUNCE_CYCLES)):
  - IDLE: s=1 → QUAL, cnt=1. Otherwise stay.
  - QUAL: s=0 → IDLE. s=1 and cnt==DEBOUNCE_CYCLES−1 → HELD, and assert the event pulse for exactly one cycle. Otherwise cnt+1.
  - HELD: s=0 → REL, cnt=1. Otherwise stay. A sustained high produces no further events.
  - REL: s=1 → HELD (glitch, no event). s=0 and cnt==DEBOUNCE_CYCLES−1 → IDLE. Otherwise cnt+1.
- Events fire on the accepted rising level only. One person produces one event regardless of how long they hold the beam.
- Latency: take edge 1 as the first clk edge that samples the raw input high, with the input held high and clean.
  - EnterPulse/LeavePulse is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - PCount, Full and Empty reflect the update after edge DEBOUNCE_CYCLES+3. With the default of 4, that is edge 7.
- Count update rules, applied on the cycle after the event pulses:
  - Enter only, PCount<MAX_COUNT: PCount+1.
  - Enter only, PCount==MAX_COUNT: PCount unchanged (entry rejected; overflow condition).
  - Leave only, PCount>0: PCount−1.
  - Leave only, PCount==0: PCount unchanged (underflow condition).
  - Enter and leave in the same cycle: PCount unchanged in every state, including full and empty. No error is raised.
- Full and Empty are registered from the next value of PCount, so they never lag PCount.
- The count never wraps.

Optional Feature:
- Macro: SBQM_ERR_FLAGS_EN.
- Defined:
  - OverflowErr sets when an enter-only event arrives while PCount==MAX_COUNT.
  - UnderflowErr sets when a leave-only event arrives while PCount==0.
  - Both flags are sticky until rst.
- Undefined:
  - No error logic is built.
  - OverflowErr and UnderflowErr are tied to 0.
  - The ports remain present so the top level is unchanged.

Test Plan:
- Reset then FrontSensor high for 10 cycles, then low → EnterPulse high for 1 cycle, PCount=1 after edge 7, Empty 1→0, and no second event while the input is held.
- FrontSensor high for 3 cycles then low (DEBOUNCE_CYCLES=4) → no EnterPulse, PCount stays 0.
- HELD glitch: FrontSensor high for 8 cycles, low for 2, high again → only one EnterPulse, PCount=1.
- 8 clean entries from empty → PCount 1..7, Full=1 after the 7th entry; the 8th entry leaves PCount=7 and, with SBQM_ERR_FLAGS_EN, sets OverflowErr=1.
- BackSensor event at PCount=0 → PCount stays 0, Empty stays 1, UnderflowErr=1 with the macro and 0 without it.
- PCount=3, then both sensors asserted on the same edge → both pulses fire together and PCount stays 3. Then assert rst mid-QUAL → all outputs return to reset values asynchronously, and no event occurs after release.
